// File: rtl/ex_mem_skid_stage.sv
// ex_mem_skid_stage: EX -> MEM pipeline boundary.
// Holds up to two ops: a main register M (drives mem_*) and a skid
// register S that absorbs one extra op when downstream stalls. Because
// of S, ex_ready_o comes straight from a flop and the ALU path is cut
// without losing throughput. Taken conditional branches produce a
// one-cycle jump_o pulse with target pc + imm. flush_i empties the stage.
// Optional build macro: EX_MEM_PERF_CNT_EN adds stall/jump counters.

// Assertion checker for the stage's internal occupancy invariants.
module ex_mem_skid_stage_chk (
  input logic clk_i,
  input logic rstn_i,
  input logic m_valid,
  input logic s_valid,
  input logic ready
);

  // S may only hold an op while M also holds one (encoding 01 is illegal).
  a_no_skid_without_main: assert property (
    @(posedge clk_i) disable iff (!rstn_i) !(s_valid && !m_valid)
  );

  // The registered ready must always mirror an empty skid slot.
  a_ready_mirrors_skid: assert property (
    @(posedge clk_i) disable iff (!rstn_i) ready == !s_valid
  );

endmodule

module ex_mem_skid_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic [DATA_WIDTH-1:0] ex_result_i,
  input  logic                  ex_flag_i,
  input  logic [4:0]            ex_rd_addr_i,
  input  logic                  ex_wb_en_i,
  input  logic                  ex_branch_i,
  input  logic [DATA_WIDTH-1:0] ex_pc_i,
  input  logic [DATA_WIDTH-1:0] ex_imm_i,
  input  logic                  flush_i,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic [DATA_WIDTH-1:0] mem_result_o,
  output logic [4:0]            mem_rd_addr_o,
  output logic                  mem_wb_en_o,
`ifdef EX_MEM_PERF_CNT_EN
  output logic [31:0]           perf_stall_cnt_o,
  output logic [31:0]           perf_jump_cnt_o,
`endif
  output logic                  jump_o,
  output logic [DATA_WIDTH-1:0] jump_target_o
);

  // Occupancy encoding {M.valid, S.valid}; 01 is unreachable.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  // Branch target: plain modular add, wrap-around is intentional.
  function automatic logic [DATA_WIDTH-1:0] branch_target(
    input logic [DATA_WIDTH-1:0] pc,
    input logic [DATA_WIDTH-1:0] imm
  );
    return pc + imm;
  endfunction

  // Stored state
  logic                  m_valid_r;
  logic                  s_valid_r;
  logic [DATA_WIDTH-1:0] m_result_r;
  logic [4:0]            m_rd_r;
  logic                  m_wb_r;
  logic [DATA_WIDTH-1:0] s_result_r;
  logic [4:0]            s_rd_r;
  logic                  s_wb_r;
  logic                  ready_r;
  logic                  jump_r;
  logic [DATA_WIDTH-1:0] target_r;

  // Next-state values
  logic                  m_valid_nxt_s;
  logic                  s_valid_nxt_s;
  logic [DATA_WIDTH-1:0] m_result_nxt_s;
  logic [4:0]            m_rd_nxt_s;
  logic                  m_wb_nxt_s;
  logic [DATA_WIDTH-1:0] s_result_nxt_s;
  logic [4:0]            s_rd_nxt_s;
  logic                  s_wb_nxt_s;
  logic                  jump_nxt_s;
  logic [DATA_WIDTH-1:0] target_nxt_s;

  // Handshake terms and the write-enable as it will be stored
  logic accept_s;
  logic drain_s;
  logic in_wb_s;

  assign accept_s = ex_valid_i & ready_r;
  assign drain_s  = m_valid_r & mem_ready_i;
  // Branches travel down the pipe for ordering but never write rd.
  assign in_wb_s  = ex_wb_en_i & ~ex_branch_i;

  // Occupancy and data movement between input, S and M.
  always_comb begin
    m_valid_nxt_s  = m_valid_r;
    s_valid_nxt_s  = s_valid_r;
    m_result_nxt_s = m_result_r;
    m_rd_nxt_s     = m_rd_r;
    m_wb_nxt_s     = m_wb_r;
    s_result_nxt_s = s_result_r;
    s_rd_nxt_s     = s_rd_r;
    s_wb_nxt_s     = s_wb_r;
    if (flush_i) begin
      // Flush wins over everything, including a same-cycle accept.
      m_valid_nxt_s = 1'b0;
      s_valid_nxt_s = 1'b0;
    end else begin
      case ({m_valid_r, s_valid_r})
        ST_EMPTY: begin
          if (accept_s) begin
            m_valid_nxt_s  = 1'b1;
            m_result_nxt_s = ex_result_i;
            m_rd_nxt_s     = ex_rd_addr_i;
            m_wb_nxt_s     = in_wb_s;
          end else begin
            m_valid_nxt_s = 1'b0;
          end
        end
        ST_ONE: begin
          if (accept_s && drain_s) begin
            // M retires and is refilled in the same cycle.
            m_result_nxt_s = ex_result_i;
            m_rd_nxt_s     = ex_rd_addr_i;
            m_wb_nxt_s     = in_wb_s;
          end else if (accept_s) begin
            // Downstream stalled: park the new op in S.
            s_valid_nxt_s  = 1'b1;
            s_result_nxt_s = ex_result_i;
            s_rd_nxt_s     = ex_rd_addr_i;
            s_wb_nxt_s     = in_wb_s;
          end else if (drain_s) begin
            m_valid_nxt_s = 1'b0;
          end else begin
            m_valid_nxt_s = 1'b1;
          end
        end
        ST_FULL: begin
          if (drain_s) begin
            // Promote the parked op; ready was low so nothing new arrives.
            s_valid_nxt_s  = 1'b0;
            m_result_nxt_s = s_result_r;
            m_rd_nxt_s     = s_rd_r;
            m_wb_nxt_s     = s_wb_r;
          end else begin
            s_valid_nxt_s = 1'b1;
          end
        end
        default: begin
          // Unreachable encoding: fall back to a clean empty stage.
          m_valid_nxt_s = 1'b0;
          s_valid_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // Branch resolution at accept; independent of downstream backpressure.
  always_comb begin
    jump_nxt_s   = ~flush_i & accept_s & ex_branch_i & ex_flag_i;
    target_nxt_s = target_r;
    if (jump_nxt_s) begin
      target_nxt_s = branch_target(ex_pc_i, ex_imm_i);
    end else begin
      target_nxt_s = target_r;
    end
  end

  // Control flops: valids, registered ready and the jump pulse.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      m_valid_r <= 1'b0;
      s_valid_r <= 1'b0;
      ready_r   <= 1'b1;
      jump_r    <= 1'b0;
      target_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      m_valid_r <= m_valid_nxt_s;
      s_valid_r <= s_valid_nxt_s;
      ready_r   <= ~s_valid_nxt_s;
      jump_r    <= jump_nxt_s;
      target_r  <= target_nxt_s;
    end
  end

  // Data flops for M and S; cleared only by reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      m_result_r <= {DATA_WIDTH{1'b0}};
      m_rd_r     <= 5'd0;
      m_wb_r     <= 1'b0;
      s_result_r <= {DATA_WIDTH{1'b0}};
      s_rd_r     <= 5'd0;
      s_wb_r     <= 1'b0;
    end else begin
      m_result_r <= m_result_nxt_s;
      m_rd_r     <= m_rd_nxt_s;
      m_wb_r     <= m_wb_nxt_s;
      s_result_r <= s_result_nxt_s;
      s_rd_r     <= s_rd_nxt_s;
      s_wb_r     <= s_wb_nxt_s;
    end
  end

`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] jump_cnt_r;

  // Saturating event counters; only reset clears them, flush does not.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stall_cnt_r <= 32'd0;
      jump_cnt_r  <= 32'd0;
    end else begin
      if (m_valid_r && !mem_ready_i && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (jump_r && (jump_cnt_r != 32'hFFFF_FFFF)) begin
        jump_cnt_r <= jump_cnt_r + 32'd1;
      end else begin
        jump_cnt_r <= jump_cnt_r;
      end
    end
  end

  assign perf_stall_cnt_o = stall_cnt_r;
  assign perf_jump_cnt_o  = jump_cnt_r;
`endif

  assign ex_ready_o    = ready_r;
  assign mem_valid_o   = m_valid_r;
  assign mem_result_o  = m_result_r;
  assign mem_rd_addr_o = m_rd_r;
  assign mem_wb_en_o   = m_wb_r;
  assign jump_o        = jump_r;
  assign jump_target_o = target_r;

  ex_mem_skid_stage_chk u_chk (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .m_valid (m_valid_r),
    .s_valid (s_valid_r),
    .ready   (ready_r)
  );

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Self-checking bench for ex_mem_skid_stage: directed vector table,
// hand-written reset / perf sequences and a randomized run against a
// queue-based reference model.
module tb_ex_mem_skid_stage;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [31:0] ex_result_i;
  logic        ex_flag_i;
  logic [4:0]  ex_rd_addr_i;
  logic        ex_wb_en_i;
  logic        ex_branch_i;
  logic [31:0] ex_pc_i;
  logic [31:0] ex_imm_i;
  logic        flush_i;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic [31:0] mem_result_o;
  logic [4:0]  mem_rd_addr_o;
  logic        mem_wb_en_o;
  logic        jump_o;
  logic [31:0] jump_target_o;
`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] perf_stall_cnt_o;
  logic [31:0] perf_jump_cnt_o;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  ex_mem_skid_stage #(.DATA_WIDTH(32)) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .ex_valid_i    (ex_valid_i),
    .ex_ready_o    (ex_ready_o),
    .ex_result_i   (ex_result_i),
    .ex_flag_i     (ex_flag_i),
    .ex_rd_addr_i  (ex_rd_addr_i),
    .ex_wb_en_i    (ex_wb_en_i),
    .ex_branch_i   (ex_branch_i),
    .ex_pc_i       (ex_pc_i),
    .ex_imm_i      (ex_imm_i),
    .flush_i       (flush_i),
    .mem_valid_o   (mem_valid_o),
    .mem_ready_i   (mem_ready_i),
    .mem_result_o  (mem_result_o),
    .mem_rd_addr_o (mem_rd_addr_o),
    .mem_wb_en_o   (mem_wb_en_o),
`ifdef EX_MEM_PERF_CNT_EN
    .perf_stall_cnt_o (perf_stall_cnt_o),
    .perf_jump_cnt_o  (perf_jump_cnt_o),
`endif
    .jump_o        (jump_o),
    .jump_target_o (jump_target_o)
  );

  typedef struct {
    logic        valid;
    logic [31:0] res;
    logic        br;
    logic        flag;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        flush;
    logic        mrdy;
    logic        e_mv;
    logic        e_rdy;
    logic [31:0] e_res;
    logic        e_wb;
    logic        e_jump;
    logic [31:0] e_tgt;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wb;
  } op_t;

  vec_t vecs[18];
  op_t  q[$];

  function automatic vec_t mk(
    input logic v, input logic [31:0] r, input logic b, input logic f,
    input logic [31:0] p, input logic [31:0] i, input logic fl, input logic mr,
    input logic emv, input logic erdy, input logic [31:0] eres,
    input logic ewb, input logic ej, input logic [31:0] et);
    vec_t x;
    x.valid = v; x.res = r; x.br = b; x.flag = f; x.pc = p; x.imm = i;
    x.flush = fl; x.mrdy = mr; x.e_mv = emv; x.e_rdy = erdy; x.e_res = eres;
    x.e_wb = ewb; x.e_jump = ej; x.e_tgt = et;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] rd,
                       input logic wb, input logic b, input logic f,
                       input logic [31:0] p, input logic [31:0] i,
                       input logic fl, input logic mr);
    ex_valid_i = v; ex_result_i = r; ex_rd_addr_i = rd; ex_wb_en_i = wb;
    ex_branch_i = b; ex_flag_i = f; ex_pc_i = p; ex_imm_i = i;
    flush_i = fl; mem_ready_i = mr;
  endtask

  task automatic idle(input logic mr);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, mr);
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic reset_pulse();
    idle(1'b1);
    rstn_i = 1'b0;
    step();
    rstn_i = 1'b1;
  endtask

  initial begin
    rstn_i = 1'b0;
    idle(1'b1);
    repeat (2) @(negedge clk_i);
    chk("reset_mem_valid", {31'd0, mem_valid_o}, 32'd0);
    chk("reset_ready", {31'd0, ex_ready_o}, 32'd1);
    chk("reset_jump", {31'd0, jump_o}, 32'd0);
    chk("reset_result", mem_result_o, 32'd0);
    chk("reset_target", jump_target_o, 32'd0);
    rstn_i = 1'b1;

    // ---------------- directed vector table ----------------
    vecs[0]  = mk(1, 32'h1, 0, 0, 0, 0, 0, 1, 1, 1, 32'h1, 1, 0, 0);
    vecs[1]  = mk(1, 32'h2, 0, 0, 0, 0, 0, 1, 1, 1, 32'h2, 1, 0, 0);
    vecs[2]  = mk(1, 32'h3, 0, 0, 0, 0, 0, 1, 1, 1, 32'h3, 1, 0, 0);
    vecs[3]  = mk(0, 32'h0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h0, 0, 0, 0);
    vecs[4]  = mk(1, 32'hA, 0, 0, 0, 0, 0, 0, 1, 1, 32'hA, 1, 0, 0);
    vecs[5]  = mk(1, 32'hB, 0, 0, 0, 0, 0, 0, 1, 0, 32'hA, 1, 0, 0);
    vecs[6]  = mk(1, 32'hC, 0, 0, 0, 0, 0, 0, 1, 0, 32'hA, 1, 0, 0);
    vecs[7]  = mk(0, 32'h0, 0, 0, 0, 0, 0, 1, 1, 1, 32'hB, 1, 0, 0);
    vecs[8]  = mk(0, 32'h0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h0, 0, 0, 0);
    vecs[9]  = mk(1, 32'h77, 1, 1, 32'h100, 32'hFFFF_FFF0, 0, 1, 1, 1, 32'h77, 0, 1, 32'hF0);
    vecs[10] = mk(1, 32'h78, 1, 0, 32'h100, 32'hFFFF_FFF0, 0, 1, 1, 1, 32'h78, 0, 0, 0);
    vecs[11] = mk(0, 32'h0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h0, 0, 0, 0);
    vecs[12] = mk(1, 32'h11, 0, 0, 0, 0, 0, 0, 1, 1, 32'h11, 1, 0, 0);
    vecs[13] = mk(1, 32'h22, 0, 0, 0, 0, 0, 0, 1, 0, 32'h11, 1, 0, 0);
    vecs[14] = mk(1, 32'h99, 1, 1, 32'h200, 32'h4, 1, 0, 0, 1, 32'h0, 0, 0, 0);
    vecs[15] = mk(1, 32'h33, 1, 1, 32'h300, 32'h8, 1, 1, 0, 1, 32'h0, 0, 0, 0);
    vecs[16] = mk(1, 32'h55, 0, 0, 0, 0, 0, 1, 1, 1, 32'h55, 1, 0, 0);
    vecs[17] = mk(0, 32'h0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h0, 0, 0, 0);

    for (int k = 0; k < 18; k++) begin
      drive(vecs[k].valid, vecs[k].res, vecs[k].res[4:0], 1'b1, vecs[k].br,
            vecs[k].flag, vecs[k].pc, vecs[k].imm, vecs[k].flush, vecs[k].mrdy);
      step();
      chk($sformatf("vec%0d_mem_valid", k), {31'd0, mem_valid_o}, {31'd0, vecs[k].e_mv});
      chk($sformatf("vec%0d_ready", k), {31'd0, ex_ready_o}, {31'd0, vecs[k].e_rdy});
      chk($sformatf("vec%0d_jump", k), {31'd0, jump_o}, {31'd0, vecs[k].e_jump});
      if (vecs[k].e_mv) begin
        chk($sformatf("vec%0d_result", k), mem_result_o, vecs[k].e_res);
        chk($sformatf("vec%0d_wb_en", k), {31'd0, mem_wb_en_o}, {31'd0, vecs[k].e_wb});
      end
      if (vecs[k].e_jump) begin
        chk($sformatf("vec%0d_target", k), jump_target_o, vecs[k].e_tgt);
      end
    end

    // ---------------- asynchronous reset with M and S full ----------------
    drive(1'b1, 32'h44, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h45, 5'd5, 1'b1, 1'b1, 1'b1, 32'h1000, 32'h10, 1'b0, 1'b0);
    step();
    chk("prereset_ready", {31'd0, ex_ready_o}, 32'd0);
    chk("prereset_jump", {31'd0, jump_o}, 32'd1);
    chk("prereset_target", jump_target_o, 32'h1010);
    idle(1'b0);
    #2 rstn_i = 1'b0;
    #1;
    chk("midreset_mem_valid", {31'd0, mem_valid_o}, 32'd0);
    chk("midreset_ready", {31'd0, ex_ready_o}, 32'd1);
    chk("midreset_jump", {31'd0, jump_o}, 32'd0);
    chk("midreset_result", mem_result_o, 32'd0);
    chk("midreset_rd", {27'd0, mem_rd_addr_o}, 32'd0);
    chk("midreset_wb_en", {31'd0, mem_wb_en_o}, 32'd0);
    chk("midreset_target", jump_target_o, 32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;

`ifdef EX_MEM_PERF_CNT_EN
    // ---------------- performance counters ----------------
    reset_pulse();
    drive(1'b1, 32'h60, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    idle(1'b0);
    repeat (3) step();
    idle(1'b1);
    step();
    drive(1'b1, 32'h61, 5'd0, 1'b0, 1'b1, 1'b1, 32'h40, 32'h4, 1'b0, 1'b1);
    step();
    drive(1'b1, 32'h62, 5'd0, 1'b0, 1'b1, 1'b1, 32'h50, 32'h4, 1'b0, 1'b1);
    step();
    idle(1'b1);
    repeat (2) step();
    chk("perf_stall_cnt", perf_stall_cnt_o, 32'd3);
    chk("perf_jump_cnt", perf_jump_cnt_o, 32'd2);
`endif

    // ---------------- randomized run against queue model ----------------
    reset_pulse();
    q.delete();
    for (int c = 0; c < 400; c++) begin
      logic        v, b, f, fl, mr, wb, acc, drn, ej;
      logic [31:0] r, p, i, et;
      logic [4:0]  rd;
      op_t         op;
      v  = ($urandom_range(0, 9) < 7);
      b  = ($urandom_range(0, 3) == 0);
      f  = $urandom_range(0, 1) == 1;
      fl = ($urandom_range(0, 15) == 0);
      mr = ($urandom_range(0, 9) < 6);
      wb = $urandom_range(0, 1) == 1;
      r  = $urandom;
      p  = $urandom;
      i  = $urandom;
      rd = 5'($urandom_range(0, 31));
      drive(v, r, rd, wb, b, f, p, i, fl, mr);
      acc = v && (q.size() < 2);
      drn = (q.size() > 0) && mr;
      ej  = !fl && acc && b && f;
      et  = p + i;
      op.res = r; op.rd = rd; op.wb = wb && !b;
      if (fl) begin
        q.delete();
      end else begin
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(op);
      end
      step();
      chk("rnd_mem_valid", {31'd0, mem_valid_o}, {31'd0, q.size() > 0});
      chk("rnd_ready", {31'd0, ex_ready_o}, {31'd0, q.size() < 2});
      chk("rnd_jump", {31'd0, jump_o}, {31'd0, ej});
      if (ej) chk("rnd_target", jump_target_o, et);
      if (q.size() > 0) begin
        chk("rnd_result", mem_result_o, q[0].res);
        chk("rnd_rd", {27'd0, mem_rd_addr_o}, {27'd0, q[0].rd});
        chk("rnd_wb_en", {31'd0, mem_wb_en_o}, {31'd0, q[0].wb});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid_stage.md
Name: ex_mem_skid_stage

Overview:
- Pipeline boundary between the execute stage (ALU result/flag plus decode sideband) and the memory/writeback stage.
- Registers ALU outputs with a valid/ready handshake and a 2-entry skid buffer, so the ALU path is cut with full throughput and a registered `ex_ready_o`.
- Resolves conditional branches from the ALU flag and emits a one-cycle redirect pulse with target `pc + imm`.
- Honours a flush from hazard control.

Parameters:
- DATA_WIDTH, 32, width of result, pc, imm and target buses.

Ports:
- clk_i  in  1  clock, rising edge
- rstn_i  in  1  reset, asynchronous, active-low
- ex_valid_i  in  1  execute stage presents a valid op
- ex_ready_o  out  1  stage can accept; registered, equals !skid_valid
- ex_result_i  in  DATA_WIDTH  ALU result_o
- ex_flag_i  in  1  ALU flag_o
- ex_rd_addr_i  in  5  destination register
- ex_wb_en_i  in  1  op writes rd
- ex_branch_i  in  1  op is conditional branch
- ex_pc_i  in  DATA_WIDTH  pc of op
- ex_imm_i  in  DATA_WIDTH  branch offset, already sign-extended
- flush_i  in  1  discard all held ops
- mem_valid_o  out  1  output register holds valid op
- mem_ready_i  in  1  downstream accepts
- mem_result_o  out  DATA_WIDTH  registered result
- mem_rd_addr_o  out  5  registered rd
- mem_wb_en_o  out  1  registered wb enable; forced 0 for branches
- jump_o  out  1  one-cycle taken-branch pulse
- jump_target_o  out  DATA_WIDTH  `pc + imm` of taken branch, valid while jump_o=1

Behaviour:
- Storage: main register M (drives mem_*) and skid register S, each with its own valid bit.
- Handshake terms:
  - accept = ex_valid_i & ex_ready_o
  - drain = mem_valid_o & mem_ready_i
- Reset (async, rstn_i=0): all valids 0, ex_ready_o=1, mem_result_o=0, mem_rd_addr_o=0, mem_wb_en_o=0, jump_o=0, jump_target_o=0.
- State encoding, from {M.valid, S.valid}:
  - EMPTY = 00
  - ONE = 10
  - FULL = 11
  - 01 is illegal and must never occur.
- EMPTY:
  - accept → load M, go to ONE.
- ONE:
  - accept & drain → load M with new op, stay in ONE.
  - accept & !drain → load S, go to FULL.
  - !accept & drain → go to EMPTY.
- FULL (ex_ready_o=0, no accept possible):
  - drain → move S into M, go to ONE.
- Latency and throughput:
  - One cycle from accept to mem_valid_o.
  - Sustained 1 op/cycle when mem_ready_i=1.
- Output stability: mem_* hold stable while mem_valid_o=1 and mem_ready_i=0.
- Branch resolution:
  - At accept, if ex_branch_i & ex_flag_i, then next cycle jump_o=1 and jump_target_o = ex_pc_i + ex_imm_i (modulo 2^DATA_WIDTH, wrap-around ignored).
  - Branches still pass to M with wb_en=0, so retirement ordering is preserved.
  - jump_o is independent of downstream backpressure.
- Flush (flush_i=1 at clock edge):
  - Next state is EMPTY.
  - A same-cycle accept is discarded.
  - jump_o=0 next cycle.
  - Flush has priority over every other event.
  - Data registers need not clear, but mem_valid_o must be 0.
- Reset mid-operation: immediate (asynchronous) return to reset values; no partially held op survives.
- Non-valid op: mem_* data values are don't-care when mem_valid_o=0, except their reset values.

Optional Feature:
- Macro: EX_MEM_PERF_CNT_EN.
- When defined, adds two outputs:
  - perf_stall_cnt_o [31:0]: increments each cycle with mem_valid_o & !mem_ready_i.
  - perf_jump_cnt_o [31:0]: increments each cycle jump_o=1.
- Both counters reset to 0, saturate at 0xFFFFFFFF and are cleared by flush_i only if flush is also asserted with reset (i.e. flush does not clear them).
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset: assert rstn_i=0 mid-stream with M and S full → immediately mem_valid_o=0, ex_ready_o=1, jump_o=0, all mem_* = 0.
- Streaming: mem_ready_i=1, send results 0x1,0x2,0x3 on consecutive cycles → mem_result_o 0x1,0x2,0x3 on the following three cycles; ex_ready_o stays 1.
- Backpressure: mem_ready_i=0 while accepting 0xA then 0xB → FULL, ex_ready_o=0, mem_result_o holds 0xA. Raise mem_ready_i → 0xA, then 0xB, no loss or duplication.
- Branch: ex_branch_i=1, ex_flag_i=1, pc=0x100, imm=0xFFFFFFF0 → next cycle jump_o=1 with jump_target_o=0x0F0, and mem_wb_en_o=0. Same op with ex_flag_i=0 → jump_o stays 0.
- Flush: FULL state plus an accept attempted with flush_i=1 → next cycle mem_valid_o=0, ex_ready_o=1, jump_o=0; the following op 0x55 passes normally.
- EX_MEM_PERF_CNT_EN defined: 3 stall cycles plus 2 taken branches → perf_stall_cnt_o=3, perf_jump_cnt_o=2.
